// File: rtl/inst_encoder_pkg.sv
// rtl/inst_encoder_pkg.sv - shared RV64I op codes, opcodes, funct3 values and format enums
package inst_encoder_pkg;

  typedef enum logic [2:0] {
    OP_ADDI  = 3'd0,
    OP_LD    = 3'd1,
    OP_ADD   = 3'd2,
    OP_AUIPC = 3'd3,
    OP_LUI   = 3'd4,
    OP_JAL   = 3'd5,
    OP_JALR  = 3'd6,
    OP_SD    = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    FMT_R = 3'd1,
    FMT_I = 3'd2,
    FMT_S = 3'd3,
    FMT_U = 3'd5,
    FMT_J = 3'd6
  } fmt_e;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_DW   = 3'b011;
  localparam logic [2:0] F3_JALR = 3'b000;
  localparam logic [6:0] F7_ADD  = 7'b0000000;

  function automatic fmt_e op_fmt(input op_e op);
    case (op)
      OP_ADD:            return FMT_R;
      OP_SD:             return FMT_S;
      OP_AUIPC, OP_LUI:  return FMT_U;
      OP_JAL:            return FMT_J;
      default:           return FMT_I;
    endcase
  endfunction

endpackage

// File: rtl/inst_encoder_pack.sv
// rtl/inst_encoder_pack.sv - combinational field packing and immediate range check
module inst_pack
  import inst_encoder_pkg::*;
(
  input  logic [2:0]  i_op,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [31:0] i_imm,
  output logic [31:0] o_inst,
  output logic        o_ok
);

  op_e        w_op;
  logic [6:0] w_opc;
  logic [2:0] w_f3;
  logic       w_is_fit;
  logic       w_j_fit;
  logic       w_u_fit;

  assign w_op = op_e'(i_op);

  // Sign-extension test: the dropped upper bits must all equal the kept sign bit.
  assign w_is_fit = (&i_imm[31:11]) | ~(|i_imm[31:11]);
  assign w_j_fit  = ((&i_imm[31:20]) | ~(|i_imm[31:20])) & ~i_imm[0];
  assign w_u_fit  = ~(|i_imm[11:0]);

  always_comb begin
    w_opc = OPC_OP_IMM;
    w_f3  = F3_ADD;
    case (w_op)
      OP_ADDI:  begin w_opc = OPC_OP_IMM; w_f3 = F3_ADD;  end
      OP_LD:    begin w_opc = OPC_LOAD;   w_f3 = F3_DW;   end
      OP_ADD:   begin w_opc = OPC_OP;     w_f3 = F3_ADD;  end
      OP_AUIPC: begin w_opc = OPC_AUIPC;  w_f3 = F3_ADD;  end
      OP_LUI:   begin w_opc = OPC_LUI;    w_f3 = F3_ADD;  end
      OP_JAL:   begin w_opc = OPC_JAL;    w_f3 = F3_ADD;  end
      OP_JALR:  begin w_opc = OPC_JALR;   w_f3 = F3_JALR; end
      OP_SD:    begin w_opc = OPC_STORE;  w_f3 = F3_DW;   end
      default:  begin w_opc = OPC_OP_IMM; w_f3 = F3_ADD;  end
    endcase
  end

  always_comb begin
    o_inst = '0;
    o_ok   = 1'b0;
    case (op_fmt(w_op))
      FMT_R: begin
        o_inst = {F7_ADD, i_rs2, i_rs1, w_f3, i_rd, w_opc};
        o_ok   = 1'b1;
      end
      FMT_I: begin
        o_inst = {i_imm[11:0], i_rs1, w_f3, i_rd, w_opc};
        o_ok   = w_is_fit;
      end
      FMT_S: begin
        o_inst = {i_imm[11:5], i_rs2, i_rs1, w_f3, i_imm[4:0], w_opc};
        o_ok   = w_is_fit;
      end
      FMT_U: begin
        o_inst = {i_imm[31:12], i_rd, w_opc};
        o_ok   = w_u_fit;
      end
      FMT_J: begin
        o_inst = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, w_opc};
        o_ok   = w_j_fit;
      end
      default: begin
        o_inst = '0;
        o_ok   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/inst_encoder.sv
// rtl/inst_encoder.sv - request handshake, encoder and fall-through output FIFO
module inst_encoder
  import inst_encoder_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [2:0]               op,
  input  logic [4:0]               rd,
  input  logic [4:0]               rs1,
  input  logic [4:0]               rs2,
  input  logic [31:0]              imm,
  output logic                     inst_valid,
  input  logic                     inst_ready,
  output logic [31:0]              inst,
  output logic                     err,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          r_err;

  logic [31:0]   w_packed;
  logic          w_ok;
  logic          w_accept;
  logic          w_push;
  logic          w_pop;

  inst_pack u_pack (
    .i_op   (op),
    .i_rd   (rd),
    .i_rs1  (rs1),
    .i_rs2  (rs2),
    .i_imm  (imm),
    .o_inst (w_packed),
    .o_ok   (w_ok)
  );

  assign req_ready  = (r_count != L_FULL);
  assign inst_valid = (r_count != '0);
  assign w_accept   = req_valid & req_ready;
  assign w_push     = w_accept & w_ok;
  assign w_pop      = inst_valid & inst_ready;
  assign inst       = inst_valid ? r_mem[r_rptr] : '0;
  assign err        = r_err;
  assign count      = r_count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_accept & ~w_ok;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_packed;
  end

endmodule

// File: tb/tb_inst_encoder.sv
// tb/tb_inst_encoder.sv - scoreboard bench for inst_encoder
module tb_inst_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  op;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic        err;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  inst_encoder #(.DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .op         (op),
    .rd         (rd),
    .rs1        (rs1),
    .rs2        (rs2),
    .imm        (imm),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst       (inst),
    .err        (err),
    .count      (count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && inst_valid === 1'b1 && inst_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pop: got %h expected no word", inst);
      end else begin
        chk("fifo_word", inst, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] o, input logic [4:0] d, input logic [4:0] s1,
                      input logic [4:0] s2, input logic [31:0] im, input logic bad,
                      input logic [31:0] ex);
    logic       rdy;
    logic [2:0] cnt_before;
    int         n;
    op = o; rd = d; rs1 = s1; rs2 = s2; imm = im;
    req_valid = 1'b1;
    n = 0;
    cnt_before = '0;
    do begin
      @(negedge clk);
      rdy = req_ready;
      cnt_before = count;
      tick();
      n++;
    end while (!rdy && n < 50);
    req_valid = 1'b0;
    if (!rdy) chk("req_timeout", 32'd0, 32'd1);
    else if (!bad) exp_q.push_back(ex);
    if (bad) begin
      chk("err_pulse", {31'd0, err}, 32'd1);
      chk("err_count_held", {29'd0, count}, {29'd0, cnt_before});
      tick();
      chk("err_one_cycle", {31'd0, err}, 32'd0);
    end
  endtask

  task automatic drain();
    int n;
    inst_ready = 1'b1;
    n = 0;
    while (count != 0 && n < 50) begin
      tick();
      n++;
    end
    chk("drain_empty", {29'd0, count}, 32'd0);
    inst_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; inst_ready = 1'b0;
    op = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
    repeat (3) tick();
    chk("rst_count", {29'd0, count}, 32'd0);
    chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    rst_n = 1'b1;
    tick();

    // first word, one cycle latency
    send(3'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 32'h00500093);
    chk("addi_head", inst, 32'h00500093);
    chk("addi_count", {29'd0, count}, 32'd1);
    drain();

    // streaming with consumer always ready: count stays at 1
    inst_ready = 1'b1;
    send(3'd7, 5'd0, 5'd3, 5'd2, 32'd8, 1'b0, 32'h0021B423);
    send(3'd1, 5'd10, 5'd2, 5'd0, 32'hFFFFFFF8, 1'b0, 32'hFF813503);
    chk("push_pop_count1", {29'd0, count}, 32'd1);
    send(3'd4, 5'd5, 5'd0, 5'd0, 32'h12345000, 1'b0, 32'h123452B7);
    send(3'd5, 5'd1, 5'd0, 5'd0, 32'd8, 1'b0, 32'h008000EF);
    send(3'd2, 5'd3, 5'd1, 5'd2, 32'hDEADBEEF, 1'b0, 32'h002081B3);
    send(3'd3, 5'd1, 5'd0, 5'd0, 32'h00001000, 1'b0, 32'h00001097);
    send(3'd6, 5'd0, 5'd1, 5'd0, 32'd0, 1'b0, 32'h00008067);
    send(3'd0, 5'd1, 5'd0, 5'd0, 32'hFFFFF800, 1'b0, 32'h80000093);
    drain();

    // range errors interleaved with boundary in-range values
    send(3'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 32'h00500093);
    send(3'd0, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b1, 32'h0);
    send(3'd7, 5'd0, 5'd3, 5'd2, 32'hFFFFF7FF, 1'b1, 32'h0);
    send(3'd5, 5'd1, 5'd0, 5'd0, 32'd3, 1'b1, 32'h0);
    send(3'd5, 5'd1, 5'd0, 5'd0, 32'h00100000, 1'b1, 32'h0);
    send(3'd4, 5'd5, 5'd0, 5'd0, 32'h00000123, 1'b1, 32'h0);
    send(3'd6, 5'd0, 5'd1, 5'd0, 32'd2047, 1'b0, 32'h7FF08067);
    send(3'd5, 5'd0, 5'd0, 5'd0, 32'hFFF00000, 1'b0, 32'h8000006F);
    chk("err_seq_count", {29'd0, count}, 32'd3);
    drain();

    // fill to full, hold fifth, then pop and push together
    send(3'd0, 5'd1, 5'd0, 5'd0, 32'd1, 1'b0, 32'h00100093);
    send(3'd0, 5'd2, 5'd0, 5'd0, 32'd2, 1'b0, 32'h00200113);
    send(3'd0, 5'd3, 5'd0, 5'd0, 32'd3, 1'b0, 32'h00300193);
    send(3'd0, 5'd4, 5'd0, 5'd0, 32'd4, 1'b0, 32'h00400213);
    chk("full_count", {29'd0, count}, 32'd4);
    chk("full_req_ready", {31'd0, req_ready}, 32'd0);
    op = 3'd0; rd = 5'd5; rs1 = 5'd0; rs2 = 5'd0; imm = 32'd5;
    req_valid = 1'b1;
    exp_q.push_back(32'h00500293);
    repeat (3) begin
      tick();
      chk("held_count", {29'd0, count}, 32'd4);
      chk("held_head", inst, 32'h00100093);
    end
    inst_ready = 1'b1;
    tick();
    chk("pop_from_full", {29'd0, count}, 32'd3);
    chk("ready_after_pop", {31'd0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
    chk("push_pop_count3", {29'd0, count}, 32'd3);
    drain();

    // reset mid-operation with count=3 and a pending err pulse
    send(3'd0, 5'd6, 5'd0, 5'd0, 32'd6, 1'b0, 32'h00600313);
    send(3'd0, 5'd7, 5'd0, 5'd0, 32'd7, 1'b0, 32'h00700393);
    send(3'd0, 5'd8, 5'd0, 5'd0, 32'd8, 1'b0, 32'h00800413);
    op = 3'd0; rd = 5'd1; rs1 = 5'd0; imm = 32'd2048;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("pre_rst_err", {31'd0, err}, 32'd1);
    chk("pre_rst_count", {29'd0, count}, 32'd3);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("mid_rst_count", {29'd0, count}, 32'd0);
    chk("mid_rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("mid_rst_inst", inst, 32'd0);
    chk("mid_rst_err", {31'd0, err}, 32'd0);
    chk("mid_rst_req_ready", {31'd0, req_ready}, 32'd1);
    tick();
    rst_n = 1'b1;
    repeat (3) begin
      tick();
      chk("post_rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    end
    send(3'd2, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, 32'h002081B3);
    chk("post_rst_head", inst, 32'h002081B3);
    drain();

    tick();
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
